// File: rtl/neuron_update_sequencer.sv
// Time-step sequencer: sweeps every neuron group through read -> threshold/fire/leak -> write-back
// and assembles the full spike vector, driving the potential selector's controls.
module neuron_update_sequencer #(
    parameter int unsigned NUM_GROUPS = 64,
    parameter int unsigned GROUP_N    = 16,
    parameter int unsigned POT_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [POT_W-1:0]                     threshold,
    input  logic [POT_W-2:0]                     leak,
    input  logic [GROUP_N*POT_W-1:0]             potential_out_16n,
    output logic [$clog2(NUM_GROUPS)-1:0]        cntrl_potential_out_sel,
    output logic [GROUP_N*POT_W-1:0]             potential_in_16n,
    output logic [$clog2(NUM_GROUPS)-1:0]        cntrl_potential_in_sel,
    output logic                                 cntrl_potential_in_ien,
    output logic [NUM_GROUPS*GROUP_N-1:0]        spk_vec,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned SEL_W   = $clog2(NUM_GROUPS);
    localparam int unsigned BUS_W   = GROUP_N * POT_W;
    localparam int unsigned SPK_W   = NUM_GROUPS * GROUP_N;
    localparam int unsigned LEAK_W  = POT_W - 1;
    localparam int unsigned ARITH_W = POT_W + 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state, state_next;
    logic [SEL_W-1:0]   g, g_next;
    logic [POT_W-1:0]   thr_q, thr_next;
    logic [LEAK_W-1:0]  leak_q, leak_next;
    logic [GROUP_N-1:0] spike_q, spike_next;
    logic [GROUP_N-1:0] upd_spk;
    logic [BUS_W-1:0]   upd_pot;

    logic [SEL_W-1:0]   out_sel_next, in_sel_next;
    logic               ien_next, busy_next, done_next;
    logic [BUS_W-1:0]   pot_in_next;
    logic [SPK_W-1:0]   spk_next;

    // Per-neuron threshold/fire/leak on the currently selected group, widened by one bit.
    always_comb begin
        upd_pot = '0;
        upd_spk = '0;
        for (int n = 0; n < GROUP_N; n++) begin
            logic signed [ARITH_W-1:0] p;
            logic signed [ARITH_W-1:0] t;
            logic signed [ARITH_W-1:0] l;
            logic signed [ARITH_W-1:0] np;
            p  = ARITH_W'($signed(potential_out_16n[n*POT_W +: POT_W]));
            t  = ARITH_W'($signed(thr_q));
            l  = ARITH_W'(leak_q);
            np = '0;
            if (p >= t) begin
                upd_spk[n] = 1'b1;
            end else if (p > l) begin
                np = p - l;
            end else if (p < -l) begin
                np = p + l;
            end
            upd_pot[n*POT_W +: POT_W] = np[POT_W-1:0];
        end
    end

    // Next state plus next value of every registered output, derived from the state being entered.
    always_comb begin
        state_next  = state;
        g_next      = g;
        thr_next    = thr_q;
        leak_next   = leak_q;
        spike_next  = spike_q;
        spk_next    = spk_vec;
        pot_in_next = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                    g_next     = '0;
                    spk_next   = '0;
                    thr_next   = threshold;
                    leak_next  = leak;
                end
            end
            READ: begin
                state_next  = WRITE;
                spike_next  = upd_spk;
                pot_in_next = upd_pot;
            end
            WRITE: begin
                spk_next[int'(g)*GROUP_N +: GROUP_N] = spike_q;
                if (g == SEL_W'(NUM_GROUPS - 1)) begin
                    state_next = DONE;
                end else begin
                    g_next     = g + SEL_W'(1);
                    state_next = READ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        out_sel_next = (state_next == READ)  ? g_next : '0;
        in_sel_next  = (state_next == WRITE) ? g_next : '0;
        ien_next     = (state_next == WRITE);
        busy_next    = (state_next != IDLE);
        done_next    = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= IDLE;
            g                       <= '0;
            thr_q                   <= '0;
            leak_q                  <= '0;
            spike_q                 <= '0;
            cntrl_potential_out_sel <= '0;
            cntrl_potential_in_sel  <= '0;
            cntrl_potential_in_ien  <= 1'b0;
            potential_in_16n        <= '0;
            spk_vec                 <= '0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
        end else begin
            state                   <= state_next;
            g                       <= g_next;
            thr_q                   <= thr_next;
            leak_q                  <= leak_next;
            spike_q                 <= spike_next;
            cntrl_potential_out_sel <= out_sel_next;
            cntrl_potential_in_sel  <= in_sel_next;
            cntrl_potential_in_ien  <= ien_next;
            potential_in_16n        <= pot_in_next;
            spk_vec                 <= spk_next;
            busy                    <= busy_next;
            done                    <= done_next;
        end
    end

endmodule

// File: tb/tb_neuron_update_sequencer.sv
// Scoreboard bench for neuron_update_sequencer with a behavioural potential-selector model.
module tb_neuron_update_sequencer;

    localparam int NG = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   threshold = '0;
    logic [6:0]   leak = '0;
    logic [127:0] potential_out_16n;
    logic [5:0]   cntrl_potential_out_sel;
    logic [127:0] potential_in_16n;
    logic [5:0]   cntrl_potential_in_sel;
    logic         cntrl_potential_in_ien;
    logic [1023:0] spk_vec;
    logic         busy;
    logic         done;

    logic [127:0] mem [NG];
    logic [127:0] init_mem [NG];
    logic         load_req = 1'b0;
    int           cyc = 0;
    int           start_cyc = 0;
    bit           active = 1'b0;
    bit           mon_en = 1'b0;
    int           n_tests = 0;
    int           n_fail = 0;

    typedef struct {
        int           g;
        logic [127:0] d;
        int           rel;
    } wr_t;
    wr_t            wq[$];
    logic [1023:0]  sq[$];

    neuron_update_sequencer dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .threshold               (threshold),
        .leak                    (leak),
        .potential_out_16n       (potential_out_16n),
        .cntrl_potential_out_sel (cntrl_potential_out_sel),
        .potential_in_16n        (potential_in_16n),
        .cntrl_potential_in_sel  (cntrl_potential_in_sel),
        .cntrl_potential_in_ien  (cntrl_potential_in_ien),
        .spk_vec                 (spk_vec),
        .busy                    (busy),
        .done                    (done)
    );

    always #5 clk = ~clk;

    // Selector model: pure read mux, registered write port.
    assign potential_out_16n = mem[cntrl_potential_out_sel];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_req) begin
            for (int g = 0; g < NG; g++) mem[g] <= init_mem[g];
        end else if (cntrl_potential_in_ien) begin
            mem[cntrl_potential_in_sel] <= potential_in_16n;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_spk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        n_tests++;
        if (act !== exp) begin
            int first;
            first = 0;
            n_fail++;
            for (int g = NG - 1; g >= 0; g--) if (act[g*16 +: 16] !== exp[g*16 +: 16]) first = g;
            $display("FAIL %s: group %0d got %h expected %h", nm, first,
                     act[first*16 +: 16], exp[first*16 +: 16]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference: apply the neuron rules to a snapshot of all groups using plain integers.
    function automatic void model(input logic [7:0] t, input logic [6:0] l);
        logic [1023:0] sv;
        sv = '0;
        for (int g = 0; g < NG; g++) begin
            logic [127:0] b;
            logic [127:0] nb;
            b  = mem[g];
            nb = '0;
            for (int n = 0; n < 16; n++) begin
                int p, th, lk, np;
                p  = int'($signed(b[n*8 +: 8]));
                th = int'($signed(t));
                lk = int'(l);
                if (p >= th) begin
                    sv[g*16 + n] = 1'b1;
                    np = 0;
                end else if (p > lk) np = p - lk;
                else if (p < -lk)   np = p + lk;
                else                np = 0;
                nb[n*8 +: 8] = 8'(np);
            end
            wq.push_back('{g, nb, 2 + 2*g});
        end
        sq.push_back(sv);
    endfunction

    task automatic pulse_start(input logic [7:0] t, input logic [6:0] l);
        bit accept;
        accept    = !active || (cyc - start_cyc >= 130);
        threshold = t;
        leak      = l;
        start     = 1'b1;
        if (accept) begin
            model(t, l);
            active    = 1'b1;
            start_cyc = cyc;
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_rel(input int k);
        while (cyc - start_cyc < k) step();
    endtask

    task automatic load_random();
        for (int g = 0; g < NG; g++)
            init_mem[g] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    // Monitor: cycle-accurate control checks plus scoreboard pops on writes and done.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            int rel;
            bit e_ien;
            rel   = active ? (cyc - start_cyc) : 1000000;
            e_ien = (rel >= 2) && (rel <= 128) && (rel % 2 == 0);
            chk("busy", 128'(busy), 128'((rel >= 1) && (rel <= 129)));
            chk("done", 128'(done), 128'(rel == 129));
            chk("out_sel", 128'(cntrl_potential_out_sel),
                ((rel >= 1) && (rel <= 127) && (rel % 2 == 1)) ? 128'((rel - 1) / 2) : 128'(0));
            chk("ien", 128'(cntrl_potential_in_ien), 128'(e_ien));
            if (cntrl_potential_in_ien) begin
                if (wq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got in_sel %0d expected no write", cntrl_potential_in_sel);
                end else begin
                    wr_t it;
                    it = wq.pop_front();
                    chk("in_sel", 128'(cntrl_potential_in_sel), 128'(it.g));
                    chk("write_data", potential_in_16n, it.d);
                    chk("write_cycle", 128'(rel), 128'(it.rel));
                end
            end else begin
                chk("idle_in_sel", 128'(cntrl_potential_in_sel), 128'(0));
                chk("idle_in_data", potential_in_16n, 128'(0));
            end
            if (done) begin
                if (sq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    chk_spk("spk_vec", spk_vec, sq.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] e;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_out_sel", 128'(cntrl_potential_out_sel), 128'(0));
        chk("rst_in_sel", 128'(cntrl_potential_in_sel), 128'(0));
        chk("rst_ien", 128'(cntrl_potential_in_ien), 128'(0));
        chk("rst_in_data", potential_in_16n, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk_spk("rst_spk", spk_vec, '0);
        mon_en = 1'b1;

        // Uniform decay
        for (int g = 0; g < NG; g++) init_mem[g] = {16{8'h05}};
        load();
        pulse_start(8'h10, 7'd2);
        wait_rel(131);
        chk_spk("decay_spk", spk_vec, '0);
        chk("decay_mem63", mem[63], {16{8'h03}});

        // Single fire at group 5 neuron 3
        for (int g = 0; g < NG; g++) init_mem[g] = '0;
        init_mem[5][31:24] = 8'h20;
        load();
        pulse_start(8'h10, 7'd1);
        wait_rel(131);
        e = '0;
        e[83] = 1'b1;
        chk_spk("fire_spk", spk_vec, e);
        chk("fire_mem5", mem[5], 128'(0));

        // Boundary values in group 0
        load_random();
        init_mem[0][47:0] = {8'h80, 8'h02, 8'hFE, 8'hF6, 8'h0F, 8'h10};
        load();
        pulse_start(8'h10, 7'd3);
        wait_rel(131);
        chk("bound_mem0", 128'(mem[0][47:0]), 128'({8'h83, 8'h00, 8'h00, 8'hF9, 8'h0C, 8'h00}));
        chk("bound_spk0", 128'(spk_vec[0]), 128'(1));

        // Handshake: ignored starts, mid-sweep input changes, back-to-back sweep
        load_random();
        load();
        pulse_start(8'($urandom), 7'($urandom));
        wait_rel(10);
        pulse_start(8'($urandom), 7'($urandom));
        wait_rel(60);
        threshold = 8'($urandom);
        leak      = 7'($urandom);
        wait_rel(129);
        pulse_start(8'($urandom), 7'($urandom));
        chk("hs_idle_after_done", 128'(busy), 128'(0));
        pulse_start(8'($urandom_range(40, 0)), 7'($urandom_range(20, 0)));
        chk_spk("hs_spk_cleared", spk_vec, '0);
        wait_rel(131);

        // Random sweeps, full threshold range
        repeat (3) begin
            load_random();
            load();
            pulse_start(8'($urandom), 7'($urandom));
            wait_rel(131);
        end

        // Abort mid-sweep with reset
        load_random();
        load();
        pulse_start(8'($urandom), 7'($urandom));
        wait_rel(50);
        rst    = 1'b1;
        active = 1'b0;
        wq.delete();
        sq.delete();
        step();
        rst = 1'b0;
        chk_spk("abort_spk", spk_vec, '0);
        chk("abort_ien", 128'(cntrl_potential_in_ien), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        repeat (20) step();

        // Recovery sweep
        load_random();
        load();
        pulse_start(8'($urandom), 7'($urandom));
        wait_rel(131);
        chk("scoreboard_empty", 128'(wq.size() + sq.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
